// File: rtl/decode_stage.sv
// decode_stage: buffered RV32I/RV64I decoder.
// Fetched instructions enter a small circular queue; the queue head is decoded
// combinationally and captured into a registered bundle for the execute stage.
module decode_stage #(
    parameter int XLEN    = 32,
    parameter int QDEPTH  = 4,
    parameter int ALUOP_W = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    input  logic               instValid,
    input  logic [31:0]        inst,
    input  logic [XLEN-1:0]    instPc,
    output logic               instReady,
    output logic               decValid,
    input  logic               decReady,
    output logic [XLEN-1:0]    decPc,
    output logic [4:0]         readAddr1,
    output logic [4:0]         readAddr2,
    output logic [4:0]         writeAddr,
    output logic [6:0]         opcode,
    output logic [2:0]         func3,
    output logic [XLEN-1:0]    immValue,
    output logic [ALUOP_W-1:0] ALUop,
    output logic               aSelPc,
    output logic               jalCSL,
    output logic [2:0]         memSize,
    output logic [1:0]         dataCacheControl,
    output logic               regWriteEnable,
    output logic               illegal
);

    localparam int PTR_W = $clog2(QDEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(QDEPTH);
    localparam logic IS64 = (XLEN == 64);

    localparam logic [ALUOP_W-1:0] ALU_NOP   = ALUOP_W'(0);
    localparam logic [ALUOP_W-1:0] ALU_ADD   = ALUOP_W'(1);
    localparam logic [ALUOP_W-1:0] ALU_SUB   = ALUOP_W'(2);
    localparam logic [ALUOP_W-1:0] ALU_SLL   = ALUOP_W'(3);
    localparam logic [ALUOP_W-1:0] ALU_SLT   = ALUOP_W'(4);
    localparam logic [ALUOP_W-1:0] ALU_SLTU  = ALUOP_W'(5);
    localparam logic [ALUOP_W-1:0] ALU_XOR   = ALUOP_W'(6);
    localparam logic [ALUOP_W-1:0] ALU_SRL   = ALUOP_W'(7);
    localparam logic [ALUOP_W-1:0] ALU_SRA   = ALUOP_W'(8);
    localparam logic [ALUOP_W-1:0] ALU_OR    = ALUOP_W'(9);
    localparam logic [ALUOP_W-1:0] ALU_AND   = ALUOP_W'(10);
    localparam logic [ALUOP_W-1:0] ALU_BEQ   = ALUOP_W'(11);
    localparam logic [ALUOP_W-1:0] ALU_BNE   = ALUOP_W'(12);
    localparam logic [ALUOP_W-1:0] ALU_BLT   = ALUOP_W'(13);
    localparam logic [ALUOP_W-1:0] ALU_BGE   = ALUOP_W'(14);
    localparam logic [ALUOP_W-1:0] ALU_BLTU  = ALUOP_W'(15);
    localparam logic [ALUOP_W-1:0] ALU_BGEU  = ALUOP_W'(16);
    localparam logic [ALUOP_W-1:0] ALU_PASSB = ALUOP_W'(17);

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    // ALU operation for the register/immediate arithmetic group
    function automatic logic [ALUOP_W-1:0] arith_op(input logic [2:0] f3, input logic alt);
        case (f3)
            3'b000:  arith_op = alt ? ALU_SUB : ALU_ADD;
            3'b001:  arith_op = ALU_SLL;
            3'b010:  arith_op = ALU_SLT;
            3'b011:  arith_op = ALU_SLTU;
            3'b100:  arith_op = ALU_XOR;
            3'b101:  arith_op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  arith_op = ALU_OR;
            default: arith_op = ALU_AND;
        endcase
    endfunction

    // ---------------- instruction queue ----------------
    logic [31:0]      q_inst [QDEPTH];
    logic [XLEN-1:0]  q_pc   [QDEPTH];
    logic [PTR_W-1:0] rd_ptr_reg, wr_ptr_reg;
    logic [CNT_W-1:0] count_reg, count_next;
    logic             inst_ready_reg;
    logic             dec_valid_reg;
    logic             do_push, do_pop;
    logic [31:0]      head_inst;
    logic [XLEN-1:0]  head_pc;

    assign do_push   = instValid && inst_ready_reg && !flush;
    assign do_pop    = (count_reg != '0) && (!dec_valid_reg || decReady) && !flush;
    assign head_inst = q_inst[rd_ptr_reg];
    assign head_pc   = q_pc[rd_ptr_reg];
    assign instReady = inst_ready_reg;

    // Occupancy after this cycle's push/pop (flush handled in the register)
    always_comb begin
        count_next = count_reg;
        if (do_push && !do_pop)
            count_next = count_reg + 1'b1;
        else if (!do_push && do_pop)
            count_next = count_reg - 1'b1;
    end

    // Queue storage: written at the tail, no reset needed
    always_ff @(posedge clk) begin
        if (do_push) begin
            q_inst[wr_ptr_reg] <= inst;
            q_pc[wr_ptr_reg]   <= instPc;
        end
    end

    // Queue pointers, occupancy and registered ready
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_ptr_reg     <= '0;
            wr_ptr_reg     <= '0;
            count_reg      <= '0;
            inst_ready_reg <= 1'b0;
        end else if (flush) begin
            rd_ptr_reg     <= '0;
            wr_ptr_reg     <= '0;
            count_reg      <= '0;
            inst_ready_reg <= 1'b1;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            count_reg      <= count_next;
            inst_ready_reg <= (count_next != FULL_COUNT);
        end
    end

    // ---------------- head decoder ----------------
    logic [6:0]         opc;
    logic [2:0]         f3;
    logic [6:0]         shift_hi;
    logic [31:0]        imm32;
    logic [ALUOP_W-1:0] alu_next;
    logic               a_sel_next, jal_next, rwe_next, bad_next;
    logic [2:0]         msize_next;
    logic [1:0]         dcc_next;
    logic [XLEN-1:0]    imm_next;

    // Classify the head instruction, build its immediate and controls
    always_comb begin
        opc        = head_inst[6:0];
        f3         = head_inst[14:12];
        imm32      = '0;
        alu_next   = ALU_NOP;
        a_sel_next = 1'b0;
        jal_next   = 1'b0;
        rwe_next   = 1'b0;
        bad_next   = (head_inst[1:0] != 2'b11);
        msize_next = 3'b000;
        dcc_next   = 2'b00;
        // Bits above shamt; on RV64 bit 25 belongs to the 6-bit shamt
        shift_hi   = head_inst[31:25];
        if (IS64) shift_hi[0] = 1'b0;
        case (opc)
            OPC_OPIMM: begin
                rwe_next = 1'b1;
                alu_next = arith_op(f3, head_inst[30] && (f3 == 3'b101));
                if (f3 == 3'b001 || f3 == 3'b101) begin
                    imm32 = {26'b0, head_inst[25] & IS64, head_inst[24:20]};
                    // SRAI may set bit 30; nothing else above shamt
                    if (f3 == 3'b001 && shift_hi != 7'b0) bad_next = 1'b1;
                    if (f3 == 3'b101 && (shift_hi & 7'b1011111) != 7'b0) bad_next = 1'b1;
                end else begin
                    imm32 = {{20{head_inst[31]}}, head_inst[31:20]};
                end
            end
            OPC_OP: begin
                rwe_next = 1'b1;
                if (head_inst[31:25] == 7'b0000000)
                    alu_next = arith_op(f3, 1'b0);
                else if (head_inst[31:25] == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101))
                    alu_next = arith_op(f3, 1'b1);
                else
                    bad_next = 1'b1;
            end
            OPC_LOAD: begin
                imm32      = {{20{head_inst[31]}}, head_inst[31:20]};
                alu_next   = ALU_ADD;
                dcc_next   = 2'b01;
                rwe_next   = 1'b1;
                msize_next = f3;
                if (f3 == 3'b111 || (!IS64 && (f3 == 3'b011 || f3 == 3'b110))) bad_next = 1'b1;
            end
            OPC_STORE: begin
                imm32      = {{20{head_inst[31]}}, head_inst[31:25], head_inst[11:7]};
                alu_next   = ALU_ADD;
                dcc_next   = 2'b10;
                msize_next = f3;
                if (f3 > 3'b010) bad_next = 1'b1;
            end
            OPC_BRANCH: begin
                imm32 = {{19{head_inst[31]}}, head_inst[31], head_inst[7],
                         head_inst[30:25], head_inst[11:8], 1'b0};
                case (f3)
                    3'b000:  alu_next = ALU_BEQ;
                    3'b001:  alu_next = ALU_BNE;
                    3'b100:  alu_next = ALU_BLT;
                    3'b101:  alu_next = ALU_BGE;
                    3'b110:  alu_next = ALU_BLTU;
                    3'b111:  alu_next = ALU_BGEU;
                    default: bad_next = 1'b1;
                endcase
            end
            OPC_LUI: begin
                imm32    = {head_inst[31:12], 12'b0};
                alu_next = ALU_PASSB;
                rwe_next = 1'b1;
            end
            OPC_AUIPC: begin
                imm32      = {head_inst[31:12], 12'b0};
                alu_next   = ALU_ADD;
                a_sel_next = 1'b1;
                rwe_next   = 1'b1;
            end
            OPC_JAL: begin
                imm32 = {{11{head_inst[31]}}, head_inst[31], head_inst[19:12],
                         head_inst[20], head_inst[30:21], 1'b0};
                alu_next   = ALU_ADD;
                jal_next   = 1'b1;
                a_sel_next = 1'b1;
                rwe_next   = 1'b1;
            end
            OPC_JALR: begin
                imm32      = {{20{head_inst[31]}}, head_inst[31:20]};
                alu_next   = ALU_ADD;
                jal_next   = 1'b1;
                a_sel_next = 1'b1;
                rwe_next   = 1'b1;
                if (f3 != 3'b000) bad_next = 1'b1;
            end
            default: bad_next = 1'b1;
        endcase
        // Illegal encodings travel down the pipe with all side effects suppressed
        if (bad_next) begin
            alu_next   = ALU_NOP;
            rwe_next   = 1'b0;
            dcc_next   = 2'b00;
            jal_next   = 1'b0;
            a_sel_next = 1'b0;
        end
        imm_next = XLEN'($signed(imm32));
    end

    // ---------------- output bundle ----------------
    logic [XLEN-1:0]    dec_pc_reg, imm_reg;
    logic [4:0]         ra1_reg, ra2_reg, wa_reg;
    logic [6:0]         opcode_reg;
    logic [2:0]         func3_reg, msize_reg;
    logic [ALUOP_W-1:0] alu_reg;
    logic               a_sel_reg, jal_reg, rwe_reg, illegal_reg;
    logic [1:0]         dcc_reg;

    // Capture the decoded head; hold it while execute stalls
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dec_valid_reg <= 1'b0;
            dec_pc_reg    <= '0;
            ra1_reg       <= '0;
            ra2_reg       <= '0;
            wa_reg        <= '0;
            opcode_reg    <= '0;
            func3_reg     <= '0;
            imm_reg       <= '0;
            alu_reg       <= '0;
            a_sel_reg     <= 1'b0;
            jal_reg       <= 1'b0;
            msize_reg     <= '0;
            dcc_reg       <= '0;
            rwe_reg       <= 1'b0;
            illegal_reg   <= 1'b0;
        end else if (flush) begin
            dec_valid_reg <= 1'b0;
        end else if (do_pop) begin
            dec_valid_reg <= 1'b1;
            dec_pc_reg    <= head_pc;
            ra1_reg       <= head_inst[19:15];
            ra2_reg       <= head_inst[24:20];
            wa_reg        <= head_inst[11:7];
            opcode_reg    <= opc;
            func3_reg     <= f3;
            imm_reg       <= imm_next;
            alu_reg       <= alu_next;
            a_sel_reg     <= a_sel_next;
            jal_reg       <= jal_next;
            msize_reg     <= msize_next;
            dcc_reg       <= dcc_next;
            rwe_reg       <= rwe_next;
            illegal_reg   <= bad_next;
        end else if (decReady) begin
            // Consumed with nothing queued behind it
            dec_valid_reg <= 1'b0;
        end
    end

    assign decValid         = dec_valid_reg;
    assign decPc            = dec_pc_reg;
    assign readAddr1        = ra1_reg;
    assign readAddr2        = ra2_reg;
    assign writeAddr        = wa_reg;
    assign opcode           = opcode_reg;
    assign func3            = func3_reg;
    assign immValue         = imm_reg;
    assign ALUop            = alu_reg;
    assign aSelPc           = a_sel_reg;
    assign jalCSL           = jal_reg;
    assign memSize          = msize_reg;
    assign dataCacheControl = dcc_reg;
    assign regWriteEnable   = rwe_reg;
    assign illegal          = illegal_reg;

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed vector table plus hand-written queue, flush and
// reset sequences for decode_stage (XLEN=32, QDEPTH=4).
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        rst_n, flush, instValid, decReady;
    logic [31:0] inst, instPc;
    logic        instReady, decValid;
    logic [31:0] decPc, immValue;
    logic [4:0]  readAddr1, readAddr2, writeAddr, ALUop;
    logic [6:0]  opcode;
    logic [2:0]  func3, memSize;
    logic        aSelPc, jalCSL, regWriteEnable, illegal;
    logic [1:0]  dataCacheControl;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    decode_stage #(.XLEN(32), .QDEPTH(4), .ALUOP_W(5)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .instValid(instValid), .inst(inst), .instPc(instPc), .instReady(instReady),
        .decValid(decValid), .decReady(decReady), .decPc(decPc),
        .readAddr1(readAddr1), .readAddr2(readAddr2), .writeAddr(writeAddr),
        .opcode(opcode), .func3(func3), .immValue(immValue), .ALUop(ALUop),
        .aSelPc(aSelPc), .jalCSL(jalCSL), .memSize(memSize),
        .dataCacheControl(dataCacheControl), .regWriteEnable(regWriteEnable),
        .illegal(illegal)
    );

    typedef struct {
        logic [31:0] inst;
        logic [31:0] imm;
        logic [4:0]  alu;
        logic [4:0]  wa;
        logic        rwe;
        logic        ill;
        logic        jal;
        logic        asel;
        logic [1:0]  dcc;
        logic [2:0]  msize;
    } vec_t;

    localparam int NVEC = 14;
    vec_t vecs [NVEC];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] addi_wa(input int i);
        addi_wa = (32'(i) << 20) | (32'(i) << 7) | 32'h13;
    endfunction

    // Push one instruction and check the bundle on the cycle it appears
    task automatic apply_vec(input int idx);
        vec_t v;
        logic [31:0] pc;
        v  = vecs[idx];
        pc = 32'h1000 + 32'(idx) * 4;
        @(negedge clk);
        instValid = 1'b1; inst = v.inst; instPc = pc;
        @(negedge clk);
        instValid = 1'b0;
        check($sformatf("v%0d.early_valid", idx), 64'(decValid), 64'd0);
        @(negedge clk);
        check($sformatf("v%0d.valid", idx), 64'(decValid), 64'd1);
        check($sformatf("v%0d.pc", idx), 64'(decPc), 64'(pc));
        check($sformatf("v%0d.imm", idx), 64'(immValue), 64'(v.imm));
        check($sformatf("v%0d.alu", idx), 64'(ALUop), 64'(v.alu));
        check($sformatf("v%0d.wa", idx), 64'(writeAddr), 64'(v.wa));
        check($sformatf("v%0d.rwe", idx), 64'(regWriteEnable), 64'(v.rwe));
        check($sformatf("v%0d.illegal", idx), 64'(illegal), 64'(v.ill));
        check($sformatf("v%0d.jal", idx), 64'(jalCSL), 64'(v.jal));
        check($sformatf("v%0d.asel", idx), 64'(aSelPc), 64'(v.asel));
        check($sformatf("v%0d.dcc", idx), 64'(dataCacheControl), 64'(v.dcc));
        check($sformatf("v%0d.msize", idx), 64'(memSize), 64'(v.msize));
        $display("vec %0d inst=%08h imm=%08h alu=%0d ill=%0b", idx, v.inst, immValue, ALUop, illegal);
    endtask

    // Push a single addi and confirm it (and only it) comes out
    task automatic push_and_expect(input string name, input int wa);
        @(negedge clk);
        instValid = 1'b1; inst = addi_wa(wa);
        @(negedge clk);
        instValid = 1'b0;
        @(negedge clk);
        check({name, ".valid"}, 64'(decValid), 64'd1);
        check({name, ".wa"}, 64'(writeAddr), 64'(wa));
        $display("%s: delivered wa=%0d", name, writeAddr);
    endtask

    initial begin
        int accepted;
        int next_i;
        logic saw_valid;

        //            inst          imm           alu wa  rwe ill jal asel dcc msize
        vecs[0]  = '{32'hFFF00093, 32'hFFFFFFFF, 1,  1,  1, 0, 0, 0, 0, 0}; // addi x1,x0,-1
        vecs[1]  = '{32'hFE000EE3, 32'hFFFFFFFC, 11, 29, 0, 0, 0, 0, 0, 0}; // beq x0,x0,-4
        vecs[2]  = '{32'h123452B7, 32'h12345000, 17, 5,  1, 0, 0, 0, 0, 0}; // lui x5,0x12345
        vecs[3]  = '{32'h0000006F, 32'h00000000, 1,  0,  1, 0, 1, 1, 0, 0}; // jal x0,0
        vecs[4]  = '{32'h00000000, 32'h00000000, 0,  0,  0, 1, 0, 0, 0, 0}; // all zero
        vecs[5]  = '{32'h40001033, 32'h00000000, 0,  0,  0, 1, 0, 0, 0, 0}; // bad func7/func3
        vecs[6]  = '{32'h0080A103, 32'h00000008, 1,  2,  1, 0, 0, 0, 1, 2}; // lw x2,8(x1)
        vecs[7]  = '{32'hFE20AE23, 32'hFFFFFFFC, 1,  28, 0, 0, 0, 0, 2, 2}; // sw x2,-4(x1)
        vecs[8]  = '{32'h4051D193, 32'h00000005, 8,  3,  1, 0, 0, 0, 0, 0}; // srai x3,x3,5
        vecs[9]  = '{32'h40519193, 32'h00000005, 0,  3,  0, 1, 0, 0, 0, 0}; // slli with bit30
        vecs[10] = '{32'h00001217, 32'h00001000, 1,  4,  1, 0, 0, 1, 0, 0}; // auipc x4,1
        vecs[11] = '{32'h004100E7, 32'h00000004, 1,  1,  1, 0, 1, 1, 0, 0}; // jalr x1,4(x2)
        vecs[12] = '{32'h407302B3, 32'h00000000, 2,  5,  1, 0, 0, 0, 0, 0}; // sub x5,x6,x7
        vecs[13] = '{32'h00002063, 32'h00000000, 0,  0,  0, 1, 0, 0, 0, 0}; // branch func3 010

        rst_n = 1'b0; flush = 1'b0; instValid = 1'b0; decReady = 1'b1;
        inst = '0; instPc = '0;
        repeat (3) @(negedge clk);
        check("reset.valid", 64'(decValid), 64'd0);
        check("reset.ready", 64'(instReady), 64'd0);
        check("reset.imm", 64'(immValue), 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("release.ready", 64'(instReady), 64'd1);

        for (int i = 0; i < NVEC; i++) apply_vec(i);

        // Backpressure: fill queue plus output register
        @(negedge clk);
        decReady = 1'b0;
        accepted = 0;
        next_i   = 1;
        for (int c = 0; c < 8; c++) begin
            instValid = 1'b1; inst = addi_wa(next_i);
            if (instReady) begin
                accepted++;
                next_i++;
            end
            @(negedge clk);
        end
        instValid = 1'b0;
        check("bp.accepted", 64'(accepted), 64'd5);
        check("bp.ready_low", 64'(instReady), 64'd0);
        check("bp.valid", 64'(decValid), 64'd1);
        check("bp.head_wa", 64'(writeAddr), 64'd1);
        $display("backpressure: accepted=%0d instReady=%0b", accepted, instReady);
        decReady = 1'b1;
        for (int k = 2; k <= 5; k++) begin
            @(negedge clk);
            check($sformatf("drain%0d.valid", k), 64'(decValid), 64'd1);
            check($sformatf("drain%0d.wa", k), 64'(writeAddr), 64'(k));
            $display("drain: wa=%0d", writeAddr);
        end
        @(negedge clk);
        check("drain.empty", 64'(decValid), 64'd0);
        check("drain.ready", 64'(instReady), 64'd1);

        // Flush with three pending and a push in the flush cycle
        decReady = 1'b0;
        for (int j = 10; j <= 12; j++) begin
            instValid = 1'b1; inst = addi_wa(j);
            @(negedge clk);
        end
        flush = 1'b1; instValid = 1'b1; inst = addi_wa(31);
        @(negedge clk);
        flush = 1'b0; instValid = 1'b0;
        check("flush.valid", 64'(decValid), 64'd0);
        check("flush.ready", 64'(instReady), 64'd1);
        decReady  = 1'b1;
        saw_valid = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (decValid) saw_valid = 1'b1;
        end
        check("flush.nothing_left", 64'(saw_valid), 64'd0);
        $display("flush: residual valid=%0b", saw_valid);
        push_and_expect("post_flush", 7);

        // Reset mid-stream
        @(negedge clk);
        decReady = 1'b0;
        for (int j = 20; j <= 22; j++) begin
            instValid = 1'b1; inst = addi_wa(j);
            @(negedge clk);
        end
        rst_n = 1'b0; inst = addi_wa(23);
        @(negedge clk);
        check("mid_rst.valid", 64'(decValid), 64'd0);
        check("mid_rst.ready", 64'(instReady), 64'd0);
        check("mid_rst.wa", 64'(writeAddr), 64'd0);
        check("mid_rst.imm", 64'(immValue), 64'd0);
        check("mid_rst.alu", 64'(ALUop), 64'd0);
        check("mid_rst.rwe", 64'(regWriteEnable), 64'd0);
        check("mid_rst.pc", 64'(decPc), 64'd0);
        rst_n = 1'b1; instValid = 1'b0;
        @(negedge clk);
        check("rst_rel.ready", 64'(instReady), 64'd1);
        check("rst_rel.valid", 64'(decValid), 64'd0);
        decReady  = 1'b1;
        saw_valid = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (decValid) saw_valid = 1'b1;
        end
        check("rst_rel.no_stale", 64'(saw_valid), 64'd0);
        $display("reset: residual valid=%0b", saw_valid);
        push_and_expect("post_reset", 9);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
